bist_checker: RTL
=================

# bist_checker

Parametrised built-in self-test receiver/checker for the router datapath. It compares a valid-qualified stream of `TEST_CHANNELS`-bit words against an internally generated LFSR pattern. It counts mismatches, records which channels failed and the first failing sample index, and aborts early once an error budget is reached. It sits at the sink end of a BIST link, paired with a transmitter built with identical `SEED`/`LFSR_WIDTH`/`TAPS`. It is re-armable at run time without reset.

## Interface
- `TEST_CHANNELS`, 70: width of the checked word.
- `LFSR_WIDTH`, 32: LFSR state width, 2..64.
- `SEED`, 32'hdeadbeef: LFSR start state, `LFSR_WIDTH` bits, must be non-zero.
- `TAPS`, 32'h80200003: feedback tap mask, `LFSR_WIDTH` bits.
- `TEST_CASES`, 1000: valid samples per run, ≥1.
- `MAX_ERRORS`, 1: mismatching samples that trigger early abort, ≥1.
- `clk`, input, 1: clock; all state changes on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: single-cycle pulse that arms a new run.
- `in_valid`, input, 1: `input_channels` holds a sample this cycle.
- `input_channels`, input, `TEST_CHANNELS`: data under test.
- `busy`, output, 1: run in progress.
- `done`, output, 1: last run finished (pass or fail); sticky until the next `start`.
- `failed`, output, 1: last run had ≥1 mismatch; sticky until the next `start`.
- `error_count`, output, 32: mismatching samples in the current/last run; saturates at 2^32-1.
- `error_mask`, output, `TEST_CHANNELS`: sticky OR of per-bit mismatches.
- `first_fail_index`, output, 32: sample index (0-based) of the first mismatch; meaningful only when `error_count` != 0.
- `output_channels`, output, `TEST_CHANNELS`: `input_channels` when `done & ~failed`, else 0 (combinational).

## Operation
- States:
  - IDLE (after reset, no run yet).
  - RUN.
  - PASS.
  - FAIL.
- Status outputs are decoded from state: `busy`=RUN, `done`=PASS|FAIL, `failed`=FAIL.
- LFSR:
  - Next state is `{lfsr[LFSR_WIDTH-2:0], ^(lfsr & TAPS)}`.
  - It is loaded with `SEED` on `start`.
  - It advances only on accepted samples.
- Expected word: `expected[i] = lfsr[i % LFSR_WIDTH]` for i in 0..`TEST_CHANNELS`-1. The pattern is replicated, not zero-extended.
- Sample k (k = 0..`TEST_CASES`-1) is compared with the LFSR after k advances; sample 0 expects `SEED`.
- On `start` in IDLE/PASS/FAIL:
  - Enter RUN.
  - Clear `cases`, `error_count`, `error_mask`, `first_fail_index`.
  - Load `SEED` into the LFSR.
- In RUN, on `in_valid` (sample accepted):
  - Compute `diff = input_channels ^ expected`.
  - `error_mask |= diff`.
  - If `diff` != 0: increment `error_count` (saturating); if it was 0, capture `first_fail_index = cases`.
  - `cases++`, LFSR advance.
- Exit RUN when either of these is true after the update:
  - `cases == TEST_CASES` → PASS if `error_count == 0`, else FAIL.
  - `error_count == MAX_ERRORS` → FAIL immediately (early abort), even if `cases < TEST_CASES`.
  - If both hold, the result is FAIL.
- In RUN, `in_valid` low: nothing changes; there is no timeout.
- `start` while in RUN is ignored.
- Samples while not in RUN are ignored.
- Results are held in PASS/FAIL until the next `start`.
- The `cases` counter is 32 bits, compared for equality only.

## Timing
- Reset (`reset_n` low, asynchronous):
  - State goes to IDLE.
  - `busy`=`done`=`failed`=0.
  - `error_count`=0, `error_mask`=0, `first_fail_index`=0.
  - `output_channels`=0.
  - LFSR=`SEED`.
- Reset asserted mid-run aborts the run with no result.
- Deassertion is sampled synchronously by the next edge.
- Arming: `start` at edge t → `busy`=1 after edge t. The first sample can be accepted at edge t+1.
- Latency: the final (or aborting) sample is accepted at edge t → `done`/`failed` are visible after edge t, and `busy`=0 in the same cycle.
- `start` together with `in_valid` while idle: `start` only; that sample is not checked.
- `output_channels` follows `input_channels` combinationally while PASS.

## Test plan
All scenarios use `TEST_CHANNELS`=8, `LFSR_WIDTH`=8, `SEED`=8'h01, `TAPS`=8'hB8, `TEST_CASES`=16, `MAX_ERRORS`=4, with a reference-model LFSR.
- Clean run: pulse `start`, drive 16 correct words (first 8'h01, then 8'h02) with `in_valid`=1 → `done`=1, `failed`=0, `error_count`=0, `error_mask`=0 one cycle after the 16th word; `output_channels` equals `input_channels` afterwards.
- Gapped valid: same as the clean run with `in_valid` toggling 1/0 → pass, `done` rises one cycle after the 16th accepted sample.
- Single fault: flip bit 3 on sample 5 only → FAIL after sample 16, `error_count`=1, `error_mask`=8'h08, `first_fail_index`=5, `output_channels`=0.
- Early abort: corrupt samples 2, 3, 7, 9 (bits 0, 0, 6, 0) → FAIL one cycle after sample 9, `busy`=0, `error_count`=4, `error_mask`=8'h41, `first_fail_index`=2; further samples change nothing.
- Re-arm and reset: `start` while RUN is ignored; `start` in FAIL clears all results and a clean run then passes; `reset_n` pulled low at sample 8 → all outputs 0 immediately, state IDLE.
- Width generality: `TEST_CHANNELS`=70, `LFSR_WIDTH`=32 defaults → bits 32..63 mirror bits 0..31 and bits 64..69 mirror bits 0..5 of the LFSR state; clean run passes.

Source files
------------

// File: rtl/bist_checker.sv
// BIST sink: checks a valid-qualified word stream against a local LFSR pattern,
// counting mismatching samples and aborting once the error budget is spent.
module bist_checker #(
  parameter int                    TEST_CHANNELS = 70,
  parameter int                    LFSR_WIDTH    = 32,
  parameter logic [LFSR_WIDTH-1:0] SEED          = 32'hdeadbeef,
  parameter logic [LFSR_WIDTH-1:0] TAPS          = 32'h80200003,
  parameter int                    TEST_CASES    = 1000,
  parameter int                    MAX_ERRORS    = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [TEST_CHANNELS-1:0] input_channels,
  output logic                     busy,
  output logic                     done,
  output logic                     failed,
  output logic [31:0]              error_count,
  output logic [TEST_CHANNELS-1:0] error_mask,
  output logic [31:0]              first_fail_index,
  output logic [TEST_CHANNELS-1:0] output_channels,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [31:0] L_TEST_CASES = 32'(TEST_CASES);
  localparam logic [31:0] L_MAX_ERRORS = 32'(MAX_ERRORS);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [LFSR_WIDTH-1:0]    r_lfsr;
  logic [31:0]              r_cases;
  logic [31:0]              r_error_count;
  logic [TEST_CHANNELS-1:0] r_error_mask;
  logic [31:0]              r_first_fail;

  logic [TEST_CHANNELS-1:0] w_expected;
  logic [TEST_CHANNELS-1:0] w_diff;
  logic                     w_accept;
  logic                     w_mismatch;
  logic [31:0]              w_err_next;
  logic [31:0]              w_cases_next;
  logic [LFSR_WIDTH-1:0]    w_lfsr_next;

  // The LFSR state is replicated across the word, not zero-extended.
  for (genvar g = 0; g < TEST_CHANNELS; g++) begin : g_expand
    assign w_expected[g] = r_lfsr[g % LFSR_WIDTH];
  end

  // in_valid qualifies a sample; there is no backpressure, so every valid
  // cycle in RUN consumes exactly one sample and advances the LFSR once.
  assign w_accept     = (r_state == S_RUN) && in_valid;
  assign w_diff       = input_channels ^ w_expected;
  assign w_mismatch   = |w_diff;
  assign w_err_next   = (w_mismatch && (r_error_count != 32'hffff_ffff)) ?
                        r_error_count + 32'd1 : r_error_count;
  assign w_cases_next = r_cases + 32'd1;
  assign w_lfsr_next  = {r_lfsr[LFSR_WIDTH-2:0], ^(r_lfsr & TAPS)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN: begin
        if (w_accept && ((w_cases_next == L_TEST_CASES) || (w_err_next == L_MAX_ERRORS))) begin
          w_next_state = (w_err_next != 32'd0) ? S_FAIL : S_PASS;
        end
      end
      default: begin
        if (start) begin
          w_next_state = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr        <= SEED;
      r_cases       <= '0;
      r_error_count <= '0;
      r_error_mask  <= '0;
      r_first_fail  <= '0;
    end else if (start && (r_state != S_RUN)) begin
      r_lfsr        <= SEED;
      r_cases       <= '0;
      r_error_count <= '0;
      r_error_mask  <= '0;
      r_first_fail  <= '0;
    end else if (w_accept) begin
      r_error_mask  <= r_error_mask | w_diff;
      r_error_count <= w_err_next;
      if (w_mismatch && (r_error_count == 32'd0)) begin
        r_first_fail <= r_cases;
      end
      r_cases       <= w_cases_next;
      r_lfsr        <= w_lfsr_next;
    end
  end

  assign busy             = (r_state == S_RUN);
  assign done             = (r_state == S_PASS) || (r_state == S_FAIL);
  assign failed           = (r_state == S_FAIL);
  assign error_count      = r_error_count;
  assign error_mask       = r_error_mask;
  assign first_fail_index = r_first_fail;
  assign output_channels  = (r_state == S_PASS) ? input_channels : '0;
  assign dbg_state        = r_state;

endmodule
